// File: rtl/hvsync_gen_param.sv
// Parameterised raster timing generator: pixel strobe, x/y counters, syncs, display enable, line/frame strobes.
// Latency: every output is registered and aligned with the x/y value presented in the same cycle.
// Backpressure: none; en low or rst low holds the timing in the zero state with syncs inactive.
`timescale 1ns/1ps
module hvsync_gen_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             clk_100,
    input  logic             rst,
    input  logic             en,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if ((CLK_DIV < 1) || (longint'(H_TOTAL - 1) > CNT_MAX) || (longint'(V_TOTAL - 1) > CNT_MAX))
    begin : g_param_check
        $error("hvsync_gen_param: illegal timing parameters");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             tick;
    logic             x_wrap;
    logic             y_wrap;
    logic             hold;
    logic             hs_act_nxt;
    logic             vs_act_nxt;
    logic             de_nxt;

    // Decodes use the next x/y so the registered outputs line up with the counters.
    always_comb begin
        hold    = !rst || !en;
        tick    = (div_q == DIV_LAST);
        x_wrap  = tick && (x == X_LAST);
        y_wrap  = x_wrap && (y == Y_LAST);
        div_nxt = tick ? '0 : div_q + 1'b1;
        x_nxt   = x;
        y_nxt   = y;
        if (tick) begin
            x_nxt = x_wrap ? '0 : x + 1'b1;
        end
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : y + 1'b1;
        end
        hs_act_nxt = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
        vs_act_nxt = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
        de_nxt     = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    end

    always_ff @(posedge clk_100) begin
        if (hold) begin
            div_q       <= '0;
            x           <= '0;
            y           <= '0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            de          <= 1'b0;
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
        end else begin
            div_q       <= div_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            pix_en      <= tick;
            line_start  <= x_wrap;
            frame_start <= y_wrap;
            de          <= de_nxt;
            hsync       <= hs_act_nxt ? HS_POL : !HS_POL;
            vsync       <= vs_act_nxt ? VS_POL : !VS_POL;
        end
    end

endmodule

// File: tb/tb_hvsync_gen_param.sv
// Directed bench for hvsync_gen_param: default timing, CLK_DIV=1 with active-high syncs,
// and a tiny raster checked every cycle against an independent timing model.
`timescale 1ns/1ps
module tb_hvsync_gen_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst, d_en, d_pix, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [10:0] d_x, d_y;
    logic        f_rst, f_en, f_pix, f_hs, f_vs, f_de, f_ls, f_fs;
    logic [10:0] f_x, f_y;
    logic        s_rst, s_en, s_pix, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [10:0] s_x, s_y;

    hvsync_gen_param u_def (
        .clk_100(clk), .rst(d_rst), .en(d_en), .pix_en(d_pix), .hsync(d_hs), .vsync(d_vs),
        .de(d_de), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    hvsync_gen_param #(.CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) u_fast (
        .clk_100(clk), .rst(f_rst), .en(f_en), .pix_en(f_pix), .hsync(f_hs), .vsync(f_vs),
        .de(f_de), .x(f_x), .y(f_y), .line_start(f_ls), .frame_start(f_fs)
    );

    hvsync_gen_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(2)
    ) u_small (
        .clk_100(clk), .rst(s_rst), .en(s_en), .pix_en(s_pix), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Small-raster model: 8 pixels x 6 lines, 2 clocks per pixel, derived from enabled-edge count.
    int m_t = 0;

    task automatic s_step();
        int p, mx, my;
        logic run, mpix, mls, mfs, mhs, mvs, mde;
        @(posedge clk);
        if (!s_rst || !s_en) m_t = 0;
        else                 m_t++;
        run  = (m_t > 0);
        p    = m_t / 2;
        mx   = p % 8;
        my   = (p / 8) % 6;
        mpix = run && (m_t % 2 == 0);
        mls  = mpix && (mx == 0);
        mfs  = mls && (my == 0);
        mhs  = run ? !(mx >= 5 && mx <= 6) : 1'b1;
        mvs  = run ? (my != 4) : 1'b1;
        mde  = run && (mx < 4) && (my < 3);
        @(negedge clk);
        chk("small_px", {4'd0, s_x, s_y, s_hs, s_vs, s_de, s_pix, s_ls, s_fs},
            {4'd0, 11'(mx), 11'(my), mhs, mvs, mde, mpix, mls, mfs});
    endtask

    initial begin
        int cyc, acc, ls_x, ls_y, ls_cnt, fs_cnt;
        int miss, hi_cnt, rise_x, ls_a, ls_b, fs_n, fs_a, fs_b, de_c, vs_c;
        logic prev_hs;

        d_rst = 1'b0; d_en = 1'b0;
        f_rst = 1'b0; f_en = 1'b0;
        s_rst = 1'b0; s_en = 1'b0;
        @(negedge clk);
        repeat (30) step();

        chk("def_rst_x", d_x, 0);
        chk("def_rst_y", d_y, 0);
        chk("def_rst_pix", d_pix, 0);
        chk("def_rst_de", d_de, 0);
        chk("def_rst_hs", d_hs, 1);
        chk("def_rst_vs", d_vs, 1);
        chk("def_rst_strobes", {d_ls, d_fs}, 0);
        chk("fast_rst_syncs", {f_hs, f_vs, f_de, f_y}, 0);

        // Default timing: first pixel strobe CLK_DIV edges after release.
        d_rst = 1'b1; d_en = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (!d_pix && cyc < 20);
        chk("def_first_pix_lat", cyc, 4);
        chk("def_first_pix_x", d_x, 1);
        cyc = 0;
        do begin step(); cyc++; end while (!d_pix && cyc < 20);
        chk("def_pix_period", cyc, 4);
        chk("def_second_pix_x", d_x, 2);

        cyc = 0;
        while (d_hs === 1'b1 && cyc < 4000) begin step(); cyc++; end
        chk("def_hs_fall_cycles", cyc, 2616);
        chk("def_hs_fall_x", d_x, 656);
        cyc = 0;
        while (d_hs === 1'b0 && cyc < 1000) begin step(); cyc++; end
        chk("def_hs_low_len", cyc, 384);
        chk("def_hs_rise_x", d_x, 752);

        ls_cnt = 0; fs_cnt = 0; ls_x = -1; ls_y = -1;
        while (d_hs === 1'b1 && cyc < 4000) begin
            step(); cyc++;
            if (d_ls) begin ls_cnt++; ls_x = d_x; ls_y = d_y; end
            if (d_fs) fs_cnt++;
        end
        chk("def_hs_period", cyc, 3200);
        chk("def_hs_fall2_y", d_y, 1);
        chk("def_ls_count", ls_cnt, 1);
        chk("def_ls_x", ls_x, 0);
        chk("def_ls_y", ls_y, 1);
        chk("def_fs_count", fs_cnt, 0);

        cyc = 0;
        while (!(d_x == 11'd639 && d_pix) && cyc < 4000) begin step(); cyc++; end
        chk("def_de_x639", {d_x, d_de}, {11'd639, 1'b1});
        cyc = 0;
        do begin step(); cyc++; end while (!d_pix && cyc < 8);
        chk("def_de_x640", {d_x, d_de}, {11'd640, 1'b0});

        // Drop en at x=300 mid-line.
        cyc = 0;
        while (!(d_x == 11'd300 && d_pix) && cyc < 4000) begin step(); cyc++; end
        chk("def_reach_x300", d_x, 300);
        d_en = 1'b0;
        step();
        chk("def_en_drop_state", {d_x, d_y, d_hs, d_vs, d_de, d_pix, d_ls, d_fs},
            {22'd0, 1'b1, 1'b1, 4'd0});
        acc = 0;
        repeat (9) begin
            step();
            acc = acc | d_pix | d_ls | d_fs | d_de | (d_x != 0) | (d_y != 0) | !d_hs | !d_vs;
        end
        chk("def_en_gap_quiet", acc, 0);
        d_en = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (!d_pix && cyc < 20);
        chk("def_restart_lat", cyc, 4);
        chk("def_restart_xy", {d_x, d_y}, {11'd1, 11'd0});

        // CLK_DIV=1 with active-high syncs.
        f_rst = 1'b1; f_en = 1'b1;
        step();
        chk("fast_first_pix", {f_pix, f_x}, {1'b1, 11'd1});
        miss = 0; hi_cnt = 0; rise_x = -1; ls_cnt = 0; ls_a = -1; ls_b = -1; fs_cnt = 0;
        prev_hs = f_hs;
        for (int i = 0; i < 1700; i++) begin
            step();
            if (!f_pix) miss++;
            if (f_hs) hi_cnt++;
            if (f_hs && !prev_hs && rise_x < 0) rise_x = f_x;
            prev_hs = f_hs;
            if (f_ls) begin
                if (ls_cnt == 0) ls_a = i;
                else if (ls_cnt == 1) ls_b = i;
                ls_cnt++;
            end
            if (f_fs) fs_cnt++;
        end
        chk("fast_pix_missing", miss, 0);
        chk("fast_hs_rise_x", rise_x, 656);
        chk("fast_hs_high_cycles", hi_cnt, 192);
        chk("fast_ls_count", ls_cnt, 2);
        chk("fast_ls_spacing", ls_b - ls_a, 800);
        chk("fast_fs_count", fs_cnt, 0);

        // Tiny raster, checked every cycle; reset held with en high first.
        s_en = 1'b1;
        repeat (3) s_step();
        s_rst = 1'b1;
        fs_n = 0; fs_a = -1; fs_b = -1; de_c = 0; vs_c = 0;
        for (int i = 0; i < 300; i++) begin
            s_step();
            if (s_fs) begin
                if (fs_n == 0) fs_a = i;
                else if (fs_n == 1) fs_b = i;
                fs_n++;
            end
            if (fs_n == 1) begin
                de_c += int'(s_de);
                vs_c += int'(!s_vs);
            end
        end
        chk("small_fs_count", fs_n, 3);
        chk("small_fs_spacing", fs_b - fs_a, 96);
        chk("small_de_per_frame", de_c, 24);
        chk("small_vs_per_frame", vs_c, 16);

        s_en = 1'b0;
        repeat (3) s_step();
        s_en = 1'b1;
        repeat (40) s_step();

        cyc = 0;
        while (s_y != 11'd4 && cyc < 200) begin s_step(); cyc++; end
        chk("small_reach_vs", s_vs, 0);
        s_rst = 1'b0;
        s_step();
        chk("small_rst_vs", {s_vs, s_y}, {1'b1, 11'd0});
        repeat (2) s_step();
        s_rst = 1'b1;
        repeat (120) s_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
